// File: rtl/commit_fence_sequencer_pkg.sv
// Shared types for the commit fence sequencer: the fence op encoding,
// the sequencer state encoding and the path-selection helper that
// decides which stage follows the current one for a given op.
package commit_fence_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_FENCE      = 2'd0,
    OP_FENCE_I    = 2'd1,
    OP_SFENCE_VMA = 2'd2,
    OP_RSVD       = 2'd3
  } fence_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_DFLUSH = 3'd2,
    ST_IFLUSH = 3'd3,
    ST_TLB    = 3'd4,
    ST_DONE   = 3'd5
  } fence_seq_state_e;

  // Stage that follows 'cur' once 'cur' has finished its work. Abort
  // handling is not part of this; the caller overrides with ST_IDLE.
  function automatic fence_seq_state_e next_stage(input fence_seq_state_e cur,
                                                  input fence_op_e        op,
                                                  input logic             dflush_en);
    fence_seq_state_e nxt;
    nxt = ST_IDLE;
    case (cur)
      ST_DRAIN: begin
        if (((op == OP_FENCE) || (op == OP_FENCE_I)) && dflush_en) begin
          nxt = ST_DFLUSH;
        end else if (op == OP_FENCE_I) begin
          nxt = ST_IFLUSH;
        end else if (op == OP_SFENCE_VMA) begin
          nxt = ST_TLB;
        end else begin
          nxt = ST_DONE;
        end
      end
      ST_DFLUSH: begin
        if (op == OP_FENCE_I) begin
          nxt = ST_IFLUSH;
        end else begin
          nxt = ST_DONE;
        end
      end
      ST_IFLUSH: nxt = ST_DONE;
      ST_TLB:    nxt = ST_DONE;
      default:   nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/commit_fence_sequencer.sv
// Commit fence sequencer: holds the commit ack of FENCE / FENCE.I /
// SFENCE.VMA until stores have drained, the D$ flush handshake is done and
// the I$/TLB invalidate pulses have gone out, then acks with a pipeline
// flush. halt/flush abort a pending sequence; an abort during the D$ flush
// is remembered and honoured once the cache acks, so the handshake is never
// left half-open.
module commit_fence_sequencer
  import commit_fence_sequencer_pkg::*;
#(
  parameter int unsigned VLEN          = 39,
  parameter int unsigned ASID_WIDTH    = 16,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned DCACHE_FLUSH  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [1:0]            req_op_i,
  input  logic [VLEN-1:0]       req_vaddr_i,
  input  logic [ASID_WIDTH-1:0] req_asid_i,
  input  logic                  halt_i,
  input  logic                  flush_i,
  input  logic                  no_st_pending_i,
  output logic                  dcache_flush_o,
  input  logic                  dcache_flush_ack_i,
  output logic                  icache_flush_o,
  output logic                  tlb_flush_o,
  output logic [VLEN-1:0]       tlb_vaddr_o,
  output logic [ASID_WIDTH-1:0] tlb_asid_o,
  output logic                  commit_ack_o,
  output logic                  flush_pipeline_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int unsigned      CNT_W     = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DRAIN_TIMEOUT);
  localparam logic             DFLUSH_EN = (DCACHE_FLUSH != 0);

  fence_seq_state_e        state;
  fence_seq_state_e        state_next;
  fence_op_e               op_q;
  logic [VLEN-1:0]         vaddr_q;
  logic [ASID_WIDTH-1:0]   asid_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    abort_q;
  logic                    timeout_q;
  logic                    dflush_q;
  logic                    iflush_q;
  logic                    tlb_q;
  logic                    done_q;
  logic                    busy_q;
  logic                    abort;
  logic                    accept;

  assign abort  = halt_i | flush_i;
  assign accept = (state == ST_IDLE) & req_valid_i & ~abort;

  // Saturating drain-cycle count for the current DRAIN visit.
  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_inc = cnt_q;
    end else begin
      cnt_inc = cnt_q + CNT_W'(1);
    end
  end

  // Next-state selection; aborts win over progress except inside DFLUSH,
  // where the cache ack must be waited for first.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (fence_op_e'(req_op_i) == OP_RSVD) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_DRAIN;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (no_st_pending_i) begin
          state_next = next_stage(ST_DRAIN, op_q, DFLUSH_EN);
        end else begin
          state_next = ST_DRAIN;
        end
      end
      ST_DFLUSH: begin
        if (dcache_flush_ack_i) begin
          if (abort_q || abort) begin
            state_next = ST_IDLE;
          end else begin
            state_next = next_stage(ST_DFLUSH, op_q, DFLUSH_EN);
          end
        end else begin
          state_next = ST_DFLUSH;
        end
      end
      ST_IFLUSH, ST_TLB: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          state_next = next_stage(state, op_q, DFLUSH_EN);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture on accept; the requester holds req_* stable anyway,
  // but the TLB outputs must not follow later changes on the bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q    <= OP_FENCE;
      vaddr_q <= '0;
      asid_q  <= '0;
    end else if (accept) begin
      op_q    <= fence_op_e'(req_op_i);
      vaddr_q <= req_vaddr_i;
      asid_q  <= req_asid_i;
    end else begin
      op_q    <= op_q;
      vaddr_q <= vaddr_q;
      asid_q  <= asid_q;
    end
  end

  // Drain counter, deferred-abort flag and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= '0;
        abort_q <= 1'b0;
      end else begin
        if (state == ST_DRAIN) begin
          cnt_q <= cnt_inc;
        end
        if ((state == ST_DFLUSH) && abort) begin
          abort_q <= 1'b1;
        end
      end
      if ((state == ST_DRAIN) && (cnt_inc == CNT_MAX)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Output flags registered from the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dflush_q <= 1'b0;
      iflush_q <= 1'b0;
      tlb_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      dflush_q <= (state_next == ST_DFLUSH);
      iflush_q <= (state_next == ST_IFLUSH);
      tlb_q    <= (state_next == ST_TLB);
      done_q   <= (state_next == ST_DONE);
      busy_q   <= (state_next != ST_IDLE);
    end
  end

  // An abort arriving in a pulse/ack cycle suppresses that pulse: the op
  // will re-execute, so a half-delivered sequence must not be acked.
  assign dcache_flush_o   = dflush_q;
  assign icache_flush_o   = iflush_q & ~abort;
  assign tlb_flush_o      = tlb_q & ~abort;
  assign commit_ack_o     = done_q & ~abort;
  assign flush_pipeline_o = done_q & ~abort;
  assign tlb_vaddr_o      = vaddr_q;
  assign tlb_asid_o       = asid_q;
  assign busy_o           = busy_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_commit_fence_sequencer.sv
// Scoreboard bench for commit_fence_sequencer. Each sequence is described
// as a timeline of phases (drain, D$ flush, I$, TLB, done) built from the
// op, drain delay, ack delay and optional abort; the expected output events
// are pushed into per-kind queues and a negedge monitor pops and compares
// them as the DUT produces them.
module tb_commit_fence_sequencer;

  localparam int VL = 39;
  localparam int AW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic [1:0]    req_op_i;
  logic [VL-1:0] req_vaddr_i;
  logic [AW-1:0] req_asid_i;
  logic          halt_i;
  logic          flush_i;
  logic          no_st_pending_i;
  logic          dcache_flush_o;
  logic          dcache_flush_ack_i;
  logic          icache_flush_o;
  logic          tlb_flush_o;
  logic [VL-1:0] tlb_vaddr_o;
  logic [AW-1:0] tlb_asid_o;
  logic          commit_ack_o;
  logic          flush_pipeline_o;
  logic          busy_o;
  logic          timeout_o;

  commit_fence_sequencer #(
    .VLEN(VL), .ASID_WIDTH(AW), .DRAIN_TIMEOUT(TO), .DCACHE_FLUSH(1)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_op_i(req_op_i),
    .req_vaddr_i(req_vaddr_i), .req_asid_i(req_asid_i), .halt_i(halt_i),
    .flush_i(flush_i), .no_st_pending_i(no_st_pending_i),
    .dcache_flush_o(dcache_flush_o), .dcache_flush_ack_i(dcache_flush_ack_i),
    .icache_flush_o(icache_flush_o), .tlb_flush_o(tlb_flush_o),
    .tlb_vaddr_o(tlb_vaddr_o), .tlb_asid_o(tlb_asid_o),
    .commit_ack_o(commit_ack_o), .flush_pipeline_o(flush_pipeline_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  int            q_dr[$];
  int            q_df[$];
  int            q_ic[$];
  int            q_tlb[$];
  int            q_ack[$];
  int            q_to[$];
  logic [VL-1:0] q_va[$];
  logic [AW-1:0] q_as[$];
  bit            model_to = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: event seen at cycle %0d, none expected", nm, cyc);
  endtask

  // Monitor: every output event pops its expected time from its queue.
  logic p_d  = 1'b0;
  logic p_to = 1'b0;
  always @(negedge clk) begin
    if (dcache_flush_o && !p_d) begin
      if (q_dr.size() == 0) unexpected("dflush_rise");
      else chk("dflush_rise_cycle", 64'(cyc), 64'(q_dr.pop_front()));
    end
    if (!dcache_flush_o && p_d) begin
      if (q_df.size() == 0) unexpected("dflush_fall");
      else chk("dflush_fall_cycle", 64'(cyc), 64'(q_df.pop_front()));
    end
    if (icache_flush_o) begin
      if (q_ic.size() == 0) unexpected("icache_flush");
      else chk("icache_flush_cycle", 64'(cyc), 64'(q_ic.pop_front()));
    end
    if (tlb_flush_o) begin
      if (q_tlb.size() == 0) unexpected("tlb_flush");
      else begin
        chk("tlb_flush_cycle", 64'(cyc), 64'(q_tlb.pop_front()));
        chk("tlb_vaddr", 64'(tlb_vaddr_o), 64'(q_va.pop_front()));
        chk("tlb_asid", 64'(tlb_asid_o), 64'(q_as.pop_front()));
      end
    end
    if (commit_ack_o) begin
      chk("flush_pipeline_with_ack", 64'(flush_pipeline_o), 64'd1);
      if (q_ack.size() == 0) unexpected("commit_ack");
      else chk("commit_ack_cycle", 64'(cyc), 64'(q_ack.pop_front()));
    end else if (flush_pipeline_o) begin
      unexpected("flush_pipeline_without_ack");
    end
    if (timeout_o && !p_to) begin
      if (q_to.size() == 0) unexpected("timeout_rise");
      else chk("timeout_rise_cycle", 64'(cyc), 64'(q_to.pop_front()));
    end
    p_d  <= dcache_flush_o;
    p_to <= timeout_o;
  end

  // One fence sequence. ab_t: cycle (relative to accept = 0) of a one-cycle
  // halt/flush (0 = none); with do_rst, rst_i is pulsed at ab_t instead.
  task automatic run_seq(input logic [1:0] op, input logic [VL-1:0] va,
                         input logic [AW-1:0] as, input int dw, input int aw,
                         input int ab_t, input bit ab_src, input bit do_rst);
    int ph[0:127];
    int c, p, te, df, tlast, idle_t, last_d, ndrain;
    bit ab, dfab, v;
    for (int i = 0; i < 128; i++) ph[i] = 0;
    c = cyc; p = 1; te = 0; df = 0;
    if (op != 2'd3) begin
      for (int i = 0; i <= dw; i++) begin ph[p] = 1; p++; end
      te = p - 1;
    end
    if (op == 2'd0 || op == 2'd1) begin
      for (int i = 0; i <= aw; i++) begin ph[p] = 2; p++; end
      df = p - 1;
    end
    if (op == 2'd1) begin ph[p] = 3; p++; end
    if (op == 2'd2) begin ph[p] = 4; p++; end
    ph[p] = 5;
    tlast = p;
    ab   = (ab_t != 0);
    dfab = ab && !do_rst && (ph[ab_t] == 2);
    last_d = 0; ndrain = 0;
    for (int k = 1; k <= tlast; k++) begin
      if (!ab) v = 1'b1;
      else if (do_rst) v = (k <= ab_t);
      else if (dfab) v = (ph[k] <= 2);
      else v = (k < ab_t);
      if (ph[k] == 1 && (!ab || k <= ab_t)) ndrain++;
      if (v) begin
        if (ph[k] == 2) begin
          if (last_d == 0) q_dr.push_back(c + k);
          last_d = k;
        end
        if (ph[k] == 3) q_ic.push_back(c + k);
        if (ph[k] == 4) begin q_tlb.push_back(c + k); q_va.push_back(va); q_as.push_back(as); end
        if (ph[k] == 5) q_ack.push_back(c + k);
      end
    end
    if (last_d != 0) q_df.push_back(c + last_d + 1);
    if (ndrain >= TO && !model_to) begin
      q_to.push_back(c + TO + 1);
      model_to = 1'b1;
    end
    if (do_rst) model_to = 1'b0;
    if (!ab) idle_t = tlast + 1;
    else if (dfab) idle_t = df + 1;
    else idle_t = ab_t + 1;

    req_op_i = op; req_vaddr_i = va; req_asid_i = as;
    for (int t = 0; t <= idle_t; t++) begin
      req_valid_i        = (t == 0) || (ab ? (t < ab_t) : (t <= tlast));
      no_st_pending_i    = (ph[t] == 1) ? (t == te) : 1'($urandom_range(0, 1));
      dcache_flush_ack_i = (ph[t] == 2) ? (t == df) : ($urandom_range(0, 7) == 0);
      halt_i             = ab && !do_rst && (t == ab_t) && !ab_src;
      flush_i            = ab && !do_rst && (t == ab_t) && ab_src;
      rst_i              = do_rst && (t == ab_t);
      @(negedge clk);
      if (t == 1) chk("busy_in_sequence", 64'(busy_o), 64'd1);
      if (t == idle_t) begin
        chk("busy_after_sequence", 64'(busy_o), 64'd0);
        if (do_rst) begin
          chk("rst_timeout_cleared", 64'(timeout_o), 64'd0);
          chk("rst_dcache_flush", 64'(dcache_flush_o), 64'd0);
          chk("rst_tlb_vaddr", 64'(tlb_vaddr_o), 64'd0);
          chk("rst_tlb_asid", 64'(tlb_asid_o), 64'd0);
        end
      end
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0; halt_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0;
  endtask

  initial begin
    int op, dw, aw, tlast, ab_t;
    rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = 2'd0; req_vaddr_i = '0;
    req_asid_i = '0; halt_i = 1'b0; flush_i = 1'b0; no_st_pending_i = 1'b0;
    dcache_flush_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_ack", 64'(commit_ack_o), 64'd0);
    chk("reset_dflush", 64'(dcache_flush_o), 64'd0);
    chk("reset_timeout", 64'(timeout_o), 64'd0);
    chk("reset_tlb_vaddr", 64'(tlb_vaddr_o), 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;

    run_seq(2'd0, 39'h0, 16'h0, 0, 0, 0, 1'b0, 1'b0);           // FENCE, ack at 3
    run_seq(2'd1, 39'h0, 16'h0, 4, 0, 0, 1'b0, 1'b0);           // FENCE_I, slow drain
    run_seq(2'd2, 39'h12345, 16'h7, 0, 0, 0, 1'b0, 1'b0);       // SFENCE_VMA
    run_seq(2'd0, 39'h0, 16'h0, 5, 0, 2, 1'b0, 1'b0);           // halt in DRAIN
    run_seq(2'd0, 39'h0, 16'h0, 0, 4, 2, 1'b1, 1'b0);           // flush in DFLUSH
    run_seq(2'd3, 39'h0, 16'h0, 0, 0, 0, 1'b0, 1'b0);           // reserved op = NOP

    // halt together with a request in IDLE: not accepted
    req_valid_i = 1'b1; req_op_i = 2'd0; halt_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0; halt_i = 1'b0;
    @(negedge clk);
    chk("halt_blocks_accept", 64'(busy_o), 64'd0);
    @(posedge clk); #1;

    run_seq(2'd0, 39'h0, 16'h0, 19, 1, 0, 1'b0, 1'b0);          // drain timeout
    @(negedge clk);
    chk("timeout_sticky", 64'(timeout_o), 64'd1);
    @(posedge clk); #1;
    run_seq(2'd0, 39'h1, 16'h1, 0, 5, 3, 1'b0, 1'b1);           // reset mid-DFLUSH

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 3));
      dw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(6, 14)) : int'($urandom_range(0, 3));
      aw = int'($urandom_range(0, 3));
      if (op == 3) tlast = 1;
      else tlast = dw + 1 + ((op < 2) ? aw + 1 : 0) + ((op != 0) ? 1 : 0) + 1;
      ab_t = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, tlast)) : 0;
      run_seq(2'(op), VL'({$urandom, $urandom}), AW'($urandom), dw, aw, ab_t,
              1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("pending_dflush_rise", 64'(q_dr.size()), 64'd0);
    chk("pending_dflush_fall", 64'(q_df.size()), 64'd0);
    chk("pending_icache", 64'(q_ic.size()), 64'd0);
    chk("pending_tlb", 64'(q_tlb.size()), 64'd0);
    chk("pending_ack", 64'(q_ack.size()), 64'd0);
    chk("pending_timeout", 64'(q_to.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
